// File: rtl/pseudo_mem_pkg.sv
// Shared encodings for the pseudo memory responder: FSM states, request
// kinds and the sizing rule for the latency counter.
package pseudo_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // The counter only ever holds LAT-1, so clog2(max latency) bits suffice.
  function automatic int cnt_width(input int rd_lat, input int wr_lat);
    int max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (max_lat < 2) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/pseudo_mem_array.sv
// Word storage with one valid bit per word: synchronous write, combinational
// read, valid bits cleared asynchronously so stale contents read as unwritten.
module pseudo_mem_array
  import pseudo_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  // NOTE: the storage array has no reset; the valid bits alone decide
  // whether a word is meaningful, which keeps the array RAM-inferable.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_valid        <= '0;
    else if (i_we) r_valid[i_idx] <= 1'b1;
  end

  assign o_rdata = r_mem[i_idx];
  assign o_valid = r_valid[i_idx];

endmodule

// File: rtl/pseudo_mem_responder.sv
// Level-handshake memory responder with separate read/write latencies;
// unwritten words read back as address+4, bad requests answer with mem_error.
module pseudo_mem_responder
  import pseudo_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 3,
  parameter int WRITE_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_error
);

  localparam int CNT_W = cnt_width(READ_LAT, WRITE_LAT);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  op_e               r_op;
  logic              r_err;
  logic              r_ready, w_ready_nxt;
  logic              r_error, w_error_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;

  logic                  w_req, w_bad_req, w_is_write, w_latch, w_we, w_arr_valid;
  logic [DATA_W-1:0]     w_arr_rdata, w_pattern;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_req      = mem_read | mem_write;
  assign w_is_write = mem_write & ~mem_read;
  assign w_bad_req  = (mem_address[1:0] != 2'b00)
                    | ((mem_address >> (DEPTH_LOG2 + 2)) != '0)
                    | (mem_read & mem_write);
  assign w_idx      = r_addr[DEPTH_LOG2+1:2];
  assign w_pattern  = DATA_W'(r_addr) + DATA_W'(4);

  pseudo_mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata),
    .o_valid (w_arr_valid)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_error_nxt = r_error;
    w_rdata_nxt = r_rdata;
    w_latch     = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_latch     = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = w_is_write ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
        end
      end
      BUSY: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = RESP;
          w_ready_nxt = 1'b1;
          if (r_err) begin
            w_error_nxt = 1'b1;
            w_rdata_nxt = '0;
          end else if (r_op == OP_WR) begin
            w_we        = 1'b1;
            w_rdata_nxt = '0;
          end else begin
            w_rdata_nxt = w_arr_valid ? w_arr_rdata : w_pattern;
          end
        end
      end
      RESP: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b0;
          w_error_nxt = 1'b0;
          w_rdata_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= OP_RD;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_error <= w_error_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_latch) begin
        r_addr  <= mem_address;
        r_wdata <= mem_wdata;
        r_op    <= w_is_write ? OP_WR : OP_RD;
        r_err   <= w_bad_req;
      end
    end
  end

  assign mem_ready = r_ready;
  assign mem_error = r_error;
  assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_pseudo_mem_responder.sv
// Directed bench: stimulus pushes expected responses, a negedge monitor pops
// and compares them whenever mem_ready rises.
module tb_pseudo_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_ready, mem_error;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_ready = 1'b0;

  always #5 clk = ~clk;

  pseudo_mem_responder #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .DEPTH_LOG2 (8),
    .READ_LAT   (3),
    .WRITE_LAT  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_error   (mem_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare the response data on each rising mem_ready.
  always @(negedge clk) begin
    if (mem_ready === 1'b1 && !prev_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata", mem_rdata, mon_e.rdata);
        check("resp_error", {31'b0, mem_error}, {31'b0, mon_e.err});
      end
    end
    prev_ready = (mem_ready === 1'b1);
  end

  task automatic wait_ready(input string name, input int lat);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (mem_ready === 1'b1) break;
    end
    check({name, "_latency"}, n - 1, lat);
  endtask

  task automatic do_req(input string name, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] exp_rdata, input bit exp_err);
    @(negedge clk);
    mem_read    = rd;
    mem_write   = wr;
    mem_address = addr;
    mem_wdata   = wdata;
    exp_q.push_back('{exp_rdata, exp_err});
    wait_ready(name, lat);
    @(negedge clk);
    check({name, "_hold_ready"}, {31'b0, mem_ready}, 32'd1);
    check({name, "_hold_rdata"}, mem_rdata, exp_rdata);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check({name, "_drop_ready"}, {31'b0, mem_ready}, 32'd0);
    check({name, "_drop_rdata"}, mem_rdata, 32'd0);
    check({name, "_drop_error"}, {31'b0, mem_error}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ready"}, {31'b0, mem_ready}, 32'd0);
    check({name, "_rdata"}, mem_rdata, 32'd0);
    check({name, "_error"}, {31'b0, mem_error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int ready_cnt;
    reset       = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    reset = 1'b0;

    // Plain read, write then read back.
    do_req("rd_10", 1, 0, 32'h10, 32'h0, 3, 32'h14, 0);
    do_req("wr_20", 0, 1, 32'h20, 32'hDEADBEEF, 2, 32'h0, 0);
    do_req("rd_20", 1, 0, 32'h20, 32'h0, 3, 32'hDEADBEEF, 0);

    // Rejected requests and aliasing check.
    do_req("rd_22_misalign", 1, 0, 32'h22, 32'h0, 3, 32'h0, 1);
    do_req("wr_400_range", 0, 1, 32'h400, 32'h5555, 2, 32'h0, 1);
    do_req("rd_0", 1, 0, 32'h0, 32'h0, 3, 32'h4, 0);
    do_req("rd_fffffffc", 1, 0, 32'hFFFFFFFC, 32'h0, 3, 32'h0, 1);
    do_req("conflict_30", 1, 1, 32'h30, 32'h9999, 3, 32'h0, 1);
    do_req("rd_30", 1, 0, 32'h30, 32'h0, 3, 32'h34, 0);

    // Write aborted after one edge: no response, no commit.
    @(negedge clk);
    mem_write   = 1'b1;
    mem_address = 32'h40;
    mem_wdata   = 32'h1234;
    @(negedge clk);
    mem_write = 1'b0;
    ready_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready === 1'b1) ready_cnt++;
    end
    check("abort_no_ready", ready_cnt, 0);
    do_req("rd_40", 1, 0, 32'h40, 32'h0, 3, 32'h44, 0);

    // Reset while BUSY clears outputs and valid bits.
    do_req("wr_50", 0, 1, 32'h50, 32'hAA, 2, 32'h0, 0);
    do_req("rd_50", 1, 0, 32'h50, 32'h0, 3, 32'hAA, 0);
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 32'h50;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset_busy");
    @(negedge clk);
    mem_read = 1'b0;
    reset    = 1'b0;
    do_req("rd_50_after_reset", 1, 0, 32'h50, 32'h0, 3, 32'h54, 0);
    do_req("rd_20_after_reset", 1, 0, 32'h20, 32'h0, 3, 32'h24, 0);

    // Reset while RESP drops the held response immediately.
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 32'h10;
    exp_q.push_back('{32'h14, 1'b0});
    wait_ready("rd_10_resp_reset", 3);
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset_resp");
    @(negedge clk);
    mem_read = 1'b0;
    reset    = 1'b0;
    do_req("rd_10_final", 1, 0, 32'h10, 32'h0, 3, 32'h14, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
